// File: rtl/lwe_pkg.sv
// Shared LWE constants, FSM state encoding and ciphertext-pair type.
// Used by both the encrypt and decrypt blocks.
package lwe_pkg;
  localparam int LWE_PT_WIDTH   = 6;
  localparam int LWE_PT_MODULUS = 64;
  localparam int LWE_CT_WIDTH   = 10;
  localparam int LWE_CT_MODULUS = 1024;
  localparam int LWE_DIMENSION  = 1;
  localparam int LWE_BIG_N      = 30;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [LWE_CT_WIDTH-1:0] top;
    logic [LWE_CT_WIDTH-1:0] bot;
  } ct_pair_t;
endpackage

// File: rtl/encrypt_if.sv
// Plaintext, public-key row and ciphertext channels of the encryptor.
// Every channel: a transfer happens on a rising edge where valid && ready; valid
// is held with stable payload until then, and ready never depends on valid.
interface encrypt_if
  import lwe_pkg::*;
#(
  parameter int PW = LWE_PT_WIDTH,
  parameter int CW = LWE_CT_WIDTH
);
  logic          pt_valid;
  logic          pt_ready;
  logic [PW-1:0] plaintext;
  logic          pk_valid;
  logic          pk_ready;
  logic [CW-1:0] pk_a;
  logic [CW-1:0] pk_b;
  logic          pk_r;
  logic          ct_valid;
  logic          ct_ready;
  logic [CW-1:0] ct_top;
  logic [CW-1:0] ct_bot;

  modport master (
    output pt_valid, plaintext, pk_valid, pk_a, pk_b, pk_r, ct_ready,
    input  pt_ready, pk_ready, ct_valid, ct_top, ct_bot
  );

  modport slave (
    input  pt_valid, plaintext, pk_valid, pk_a, pk_b, pk_r, ct_ready,
    output pt_ready, pk_ready, ct_valid, ct_top, ct_bot
  );
endinterface

// File: rtl/lwe_mod_accum.sv
// Gated modular accumulator: load has priority over add; sums wrap mod 2^W.
module lwe_mod_accum #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_add_en,
  input  logic [W-1:0] i_add_val,
  output logic [W-1:0] o_acc
);
  logic [W-1:0] r_acc;

  always_ff @(posedge clk) begin
    if (rst)           r_acc <= '0;
    else if (i_load)   r_acc <= i_load_val;
    else if (i_add_en) r_acc <= r_acc + i_add_val;
  end

  assign o_acc = r_acc;
endmodule

// File: rtl/encrypt.sv
// Sequential LWE encryptor: takes a plaintext, folds BIG_N selected key rows into
// (ct_top, ct_bot) mod q and holds the pair until the consumer takes it.
module encrypt
  import lwe_pkg::*;
#(
  parameter int PLAINTEXT_MODULUS  = LWE_PT_MODULUS,
  parameter int PLAINTEXT_WIDTH    = LWE_PT_WIDTH,
  parameter int DIMENSION          = LWE_DIMENSION,
  parameter int CIPHERTEXT_MODULUS = LWE_CT_MODULUS,
  parameter int CIPHERTEXT_WIDTH   = LWE_CT_WIDTH,
  parameter int BIG_N              = LWE_BIG_N
) (
  input  logic            clk,
  input  logic            rst,
  encrypt_if.slave        bus,
  output state_t          o_dbg_state
);
  localparam int CNT_W = $clog2(BIG_N + 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(BIG_N - 1);

  generate
    if (DIMENSION != 1) begin : g_bad_dimension
      $error("encrypt: only DIMENSION == 1 is supported");
    end
    if (BIG_N < 1) begin : g_bad_big_n
      $error("encrypt: BIG_N must be at least 1");
    end
    if (PLAINTEXT_MODULUS != (1 << PLAINTEXT_WIDTH)) begin : g_bad_pt_mod
      $error("encrypt: PLAINTEXT_MODULUS must be 2**PLAINTEXT_WIDTH");
    end
    if (CIPHERTEXT_MODULUS != (1 << CIPHERTEXT_WIDTH)) begin : g_bad_ct_mod
      $error("encrypt: CIPHERTEXT_MODULUS must be 2**CIPHERTEXT_WIDTH");
    end
  endgenerate

  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_row_cnt;
  logic                  w_pt_fire;
  logic                  w_pk_fire;
  logic                  w_ct_fire;
  logic                  w_last_row;
  logic [CIPHERTEXT_WIDTH-1:0] w_pt_ext;
  logic [CIPHERTEXT_WIDTH-1:0] w_top_acc;
  logic [CIPHERTEXT_WIDTH-1:0] w_bot_acc;

  // Handshakes qualify only on registered state, so no input reaches an output.
  assign w_pt_fire  = bus.pt_valid && (r_state == ST_IDLE);
  assign w_pk_fire  = bus.pk_valid && (r_state == ST_ACCUM);
  assign w_ct_fire  = bus.ct_ready && (r_state == ST_DONE);
  assign w_last_row = (r_row_cnt == LAST_ROW);
  assign w_pt_ext   = CIPHERTEXT_WIDTH'(bus.plaintext);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    bus.pt_ready = 1'b0;
    bus.pk_ready = 1'b0;
    bus.ct_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.pt_ready = 1'b1;
        if (w_pt_fire) w_next = ST_ACCUM;
      end
      ST_ACCUM: begin
        bus.pk_ready = 1'b1;
        if (w_pk_fire && w_last_row) w_next = ST_DONE;
      end
      ST_DONE: begin
        bus.ct_valid = 1'b1;
        if (w_ct_fire) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Counter wraps to 0 on the final row so it never exceeds BIG_N-1.
  always_ff @(posedge clk) begin
    if (rst)            r_row_cnt <= '0;
    else if (w_pt_fire) r_row_cnt <= '0;
    else if (w_pk_fire) r_row_cnt <= w_last_row ? '0 : r_row_cnt + 1'b1;
  end

  lwe_mod_accum #(.W(CIPHERTEXT_WIDTH)) u_top_acc (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_pt_fire),
    .i_load_val (w_pt_ext),
    .i_add_en   (w_pk_fire && bus.pk_r),
    .i_add_val  (bus.pk_b),
    .o_acc      (w_top_acc)
  );

  lwe_mod_accum #(.W(CIPHERTEXT_WIDTH)) u_bot_acc (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_pt_fire),
    .i_load_val ('0),
    .i_add_en   (w_pk_fire && bus.pk_r),
    .i_add_val  (bus.pk_a),
    .o_acc      (w_bot_acc)
  );

  assign bus.ct_top  = w_top_acc;
  assign bus.ct_bot  = w_bot_acc;
  assign o_dbg_state = r_state;
endmodule

// File: doc/encrypt.md
# encrypt

Sequential LWE encryptor, the transmit-side counterpart of the team's `decrypt` block. It accepts one plaintext, then streams `BIG_N` public-key rows, each qualified by one random selection bit. It accumulates the subset sum modulo `CIPHERTEXT_MODULUS` and presents the ciphertext pair (`ct_top`, `ct_bot`) through a valid/ready handshake. The pair is formatted so that `decrypt` recovers the plaintext as the low `PLAINTEXT_WIDTH` bits of `ct_top + sk*ct_bot`.

## Interface
Parameters:
- `PLAINTEXT_MODULUS`, default 64: plaintext modulus, equal to 2^`PLAINTEXT_WIDTH`.
- `PLAINTEXT_WIDTH`, default 6: plaintext bit width.
- `DIMENSION`, default 1: LWE dimension. Only the value 1 is supported; any other value fails elaboration.
- `CIPHERTEXT_MODULUS`, default 1024: q, equal to 2^`CIPHERTEXT_WIDTH`.
- `CIPHERTEXT_WIDTH`, default 10: ciphertext word width.
- `BIG_N`, default 30: number of public-key rows per encryption. Must be ≥ 1.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `pt_valid`, in, 1: plaintext offered.
- `pt_ready`, out, 1: block is idle and accepts a plaintext.
- `plaintext`, in, `PLAINTEXT_WIDTH`: message.
- `pk_valid`, in, 1: public-key row offered.
- `pk_ready`, out, 1: block accepts a row.
- `pk_a`, in, `CIPHERTEXT_WIDTH`: row term a_i.
- `pk_b`, in, `CIPHERTEXT_WIDTH`: row term b_i.
- `pk_r`, in, 1: selection bit r_i for this row.
- `ct_valid`, out, 1: ciphertext available.
- `ct_ready`, in, 1: consumer accepts the ciphertext.
- `ct_top`, out, `CIPHERTEXT_WIDTH`: equals Σ r_i·b_i + plaintext, mod q.
- `ct_bot`, out, `CIPHERTEXT_WIDTH`: equals Σ r_i·a_i, mod q.

## Operation
- The FSM has three states: IDLE, ACCUM and DONE.
- **IDLE**
  - `pt_ready`=1, `pk_ready`=0, `ct_valid`=0.
  - On `pt_valid`&&`pt_ready`: load `top_acc` ← zero-extended `plaintext`, `bot_acc` ← 0, `row_cnt` ← 0, then go to ACCUM.
- **ACCUM**
  - `pk_ready`=1, `pt_ready`=0.
  - Each `pk_valid`&&`pk_ready` handshake performs:
    - `top_acc` += `pk_r` ? `pk_b` : 0
    - `bot_acc` += `pk_r` ? `pk_a` : 0
    - `row_cnt`++
  - Cycles without `pk_valid` change nothing.
  - A handshake with `row_cnt`==`BIG_N`-1 moves the FSM to DONE.
- **DONE**
  - `ct_valid`=1. `ct_top`/`ct_bot` are driven from the accumulators and stay stable until the handshake.
  - `pk_ready`=0 and `pt_ready`=0.
  - On `ct_valid`&&`ct_ready`: go to IDLE.
- Arithmetic is unsigned modulo 2^`CIPHERTEXT_WIDTH`. Adders keep only the low `CIPHERTEXT_WIDTH` bits, so wrap-around is silent.
- `row_cnt` width is $clog2(`BIG_N`+1). It never exceeds `BIG_N`-1.
- Key contract: the host supplies `pk_b` = (−sk·`pk_a` + e_i) mod q. With all e_i=0, `decrypt` then returns `plaintext` exactly.
- Boundary cases:
  - A `pk_valid` presented in IDLE or DONE is not consumed, because `pk_ready`=0.
  - A `pt_valid` presented in ACCUM or DONE is not consumed.
  - There is no DONE→IDLE→ACCUM bypass. A new plaintext is accepted no earlier than the cycle after the `ct` handshake.
  - `rst` asserted in any state aborts the operation: the FSM goes to IDLE and all accumulators and the counter clear on that edge.

## Timing
- Reset values after the `rst` edge:
  - state=IDLE, `pt_ready`=1, `pk_ready`=0, `ct_valid`=0
  - `ct_top`=0, `ct_bot`=0, `row_cnt`=0
- `pt_ready`, `pk_ready` and `ct_valid` decode directly from registered state. There is no combinational path from any `*_valid` or `ct_ready` input to any output.
- Latency with the plaintext handshake in cycle T and `pk_valid` held high:
  - Rows are consumed in cycles T+1 through T+`BIG_N`.
  - `ct_valid` rises at T+`BIG_N`+1.
- Throughput: one row per cycle. Each encryption takes at least `BIG_N`+2 cycles end to end.

## Structure
- A shared package `lwe_pkg` holds:
  - the width and modulus constants
  - the state enum (IDLE, ACCUM, DONE)
  - the ciphertext-pair struct, shared with `decrypt`
- Optional sub-module `lwe_mod_accum`: one gated modular accumulator (load, add-if-enable). It is instantiated twice, once for top and once for bot.

## Test plan
1. **Zero selection.** Stimulus: `plaintext`=5, 30 rows all with `pk_r`=0. Response: `ct_top`=5, `ct_bot`=0, `ct_valid` at T+31.
2. **All selected, no wrap.** Stimulus: `plaintext`=3, every row `pk_a`=1, `pk_b`=2, `pk_r`=1. Response: `ct_bot`=30, `ct_top`=63.
3. **Wrap.** Stimulus: `plaintext`=7, every row `pk_a`=1023, `pk_b`=1000, `pk_r`=1. Response: `ct_bot`=994, `ct_top`=311.
4. **Backpressure and gaps.**
   - Stimulus: `pk_valid` toggles every other cycle; `ct_ready` is held low for 5 cycles after `ct_valid` rises.
   - Response: results match test 2. Outputs are stable while `ct_ready`=0, `pt_ready`=0 throughout, and `pt_ready`=1 the cycle after the handshake.
5. **Reset mid-operation.** Stimulus: `rst` asserted after 10 rows, then a full test-1 run. Response: `ct_valid`=0 and `pt_ready`=1 after reset; the new result shows no residue from the aborted run.
6. **Round-trip.** Stimulus: sk=37, random `pk_a`, `pk_b`=(−37·`pk_a`) mod 1024, random `pk_r`, every plaintext 0..63. Response: `decrypt` output equals `plaintext` for all cases.
